mips_cache_instr_plru: RTL and testbench

MIPS_CACHE_INSTR_PLRU -- requirements
Module: mips_cache_instr_plru

---
 rtl/mips_cache_pkg.sv | 24 ++
 rtl/mips_cache_plru.sv | 50 +++++
 rtl/mips_cache_instr_plru.sv | 143 ++++++++++++++
 tb/tb_mips_cache_instr_plru.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cache_pkg.sv
// Shared types and address-split helpers for the instruction cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mips_cache_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    localparam int ADDR_W   = 32;
    localparam int WORD_OFF = 2;

    // Index width for a cache with the given number of sets.
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: everything above the word offset and the index.
    function automatic int tag_bits(input int sets);
        return ADDR_W - WORD_OFF - $clog2(sets);
    endfunction

endpackage

// File: rtl/mips_cache_plru.sv
// Tree-PLRU for one set: victim from current bits, next bits after touching a way.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the next bits are committed.
module mips_cache_plru #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits_i,
    input  logic [$clog2(WAYS)-1:0] way_i,
    output logic [WAYS-2:0]         bits_o,
    output logic [$clog2(WAYS)-1:0] victim_o
);
    localparam int LVLS  = $clog2(WAYS);
    localparam int WAY_W = $clog2(WAYS);

    // Depth of heap node n (root is depth 0).
    function automatic int lvl_of(input int n);
        int l;
        l = 0;
        for (int k = 0; k < 16; k++) begin
            if (((2 << k) - 1) <= n) l = k + 1;
        end
        return l;
    endfunction

    // Point every node on the accessed way's path away from it (0 = go left, 1 = go right).
    always_comb begin
        bits_o = bits_i;
        for (int n = 0; n < WAYS - 1; n++) begin
            if ((int'(way_i) >> (LVLS - lvl_of(n))) == (n + 1 - (1 << lvl_of(n)))) begin
                bits_o[n] = (((int'(way_i) >> (LVLS - 1 - lvl_of(n))) & 1) == 0);
            end
        end
    end

    // Follow the node bits from the root down to a leaf to find the victim.
    always_comb begin : victim_walk
        int   node;
        logic b;
        node = 0;
        for (int lvl = 0; lvl < LVLS; lvl++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == node) b = bits_i[n];
            end
            node = 2 * node + 1 + (b ? 1 : 0);
        end
        victim_o = WAY_W'(node - (WAYS - 1));
    end

endmodule

// File: rtl/mips_cache_instr_plru.sv
// Set-associative instruction cache, one word per line, tree-PLRU replacement.
// Latency: hit returns data in the request cycle; miss returns data in the mem_valid cycle.
// Backpressure: stall held high until hit or refill data; CPU must hold addr/read_en.
module mips_cache_instr_plru
    import mips_cache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        read_en,
    output logic [31:0] readdata,
    output logic        stall,
    input  logic        flush,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_readdata,
    input  logic        mem_valid
);
    localparam int IDX_W = idx_bits(SETS);
    localparam int TAG_W = tag_bits(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_addr_bits;

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [WAYS-2:0]  plru_d  [SETS];
    state_e           state_q, state_d;

    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way, inv_way, plru_victim, victim, acc_way;
    logic [31:0]      hit_data;
    logic             inv_found, hit, in_refill, fill, hit_upd;
    logic [WAYS-2:0]  plru_next;

    assign idx              = addr[WORD_OFF +: IDX_W];
    assign tag              = addr[31 -: TAG_W];
    assign unused_addr_bits = ^addr[1:0];

    // Tag compare across the indexed set; at most one way can match.
    always_comb begin
        hit_vec  = '0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
                hit_data   = data_q[idx][w];
            end
        end
    end

    // Lowest-index invalid way wins; PLRU only matters once the set is full.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign hit       = read_en & (|hit_vec);
    assign in_refill = (state_q == ST_REFILL);
    assign fill      = in_refill & mem_valid & ~rst;
    assign hit_upd   = hit & (state_q == ST_IDLE) & ~rst;
    assign victim    = inv_found ? inv_way : plru_victim;
    assign acc_way   = hit ? hit_way : victim;

    mips_cache_plru #(.WAYS(WAYS)) u_plru (
        .bits_i   (plru_q[idx]),
        .way_i    (acc_way),
        .bits_o   (plru_next),
        .victim_o (plru_victim)
    );

    // CPU-facing outputs; reset masks the handshake so nothing leaks from a stale refill.
    always_comb begin
        stall    = ~rst & read_en & ~hit & ~(in_refill & mem_valid);
        mem_read = ~rst & (((state_q == ST_IDLE) & read_en & ~hit) | in_refill);
        mem_addr = {addr[31:2], 2'b00};
        readdata = '0;
        if (read_en) begin
            if (hit)                         readdata = hit_data;
            else if (in_refill && mem_valid) readdata = mem_readdata;
        end
    end

    // Refill FSM: leave IDLE on a miss, return when the memory word arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (read_en && !hit) state_d = ST_REFILL;
            ST_REFILL: if (mem_valid)       state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
        if (rst) state_d = ST_IDLE;
    end

    // Valid/PLRU next state; flush and reset override any fill or hit update.
    always_comb begin
        valid_d = valid_q;
        plru_d  = plru_q;
        if (rst || flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
                plru_d[s]  = '0;
            end
        end else if (fill) begin
            valid_d[idx][victim] = 1'b1;
            plru_d[idx]          = plru_next;
        end else if (hit_upd) begin
            plru_d[idx] = plru_next;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        valid_q <= valid_d;
        plru_q  <= plru_d;
    end

    // Tag/data arrays are write-only on fill and need no reset.
    always_ff @(posedge clk) begin
        if (fill && !flush) begin
            tag_q[idx][victim]  <= tag;
            data_q[idx][victim] <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_mips_cache_instr_plru.sv
module tb_mips_cache_instr_plru;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        read_en;
    logic [31:0] readdata;
    logic        stall;
    logic        flush;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_readdata;
    logic        mem_valid;

    int tests = 0;
    int fails = 0;

    mips_cache_instr_plru #(.WAYS(4), .SETS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .read_en      (read_en),
        .readdata     (readdata),
        .stall        (stall),
        .flush        (flush),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_readdata (mem_readdata),
        .mem_valid    (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    // Issue one read; sample outputs in the request cycle, then complete a refill with fd if it missed.
    task automatic probe(input logic [31:0] a, input logic [31:0] fd,
                         output logic st, output logic mr,
                         output logic [31:0] rd, output logic [31:0] ma);
        addr      = a;
        read_en   = 1'b1;
        mem_valid = 1'b0;
        #1;
        st = stall;
        mr = mem_read;
        rd = readdata;
        ma = mem_addr;
        cyc();
        if (st) begin
            mem_valid    = 1'b1;
            mem_readdata = fd;
            cyc();
            mem_valid = 1'b0;
        end
        read_en = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        read_en = 1'b1;
        addr    = 32'h40;
        #2;
        tests++;
        if (stall !== 1'b0 || mem_read !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: stall=%b mem_read=%b, want 0/0", stall, mem_read);
        end
        cyc();
        cyc();
        rst     = 1'b0;
        read_en = 1'b0;
        #1;
        tests++;
        if (stall !== 1'b0 || mem_read !== 1'b0 || readdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_idle: stall=%b mem_read=%b readdata=%h, want 0/0/0", stall, mem_read, readdata);
        end
    endtask

    task automatic test_cold_miss();
        addr    = 32'h40;
        read_en = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b1 || mem_read !== 1'b1 || readdata !== 32'h0) begin
            fails++;
            $display("FAIL cold_miss: stall=%b mem_read=%b readdata=%h, want 1/1/0", stall, mem_read, readdata);
        end
        tests++;
        if (mem_addr !== 32'h40) begin
            fails++;
            $display("FAIL cold_miss_addr: mem_addr=%h, want 00000040", mem_addr);
        end
        cyc();
        #1;
        tests++;
        if (stall !== 1'b1 || mem_read !== 1'b1) begin
            fails++;
            $display("FAIL refill_hold: stall=%b mem_read=%b, want 1/1", stall, mem_read);
        end
        mem_valid    = 1'b1;
        mem_readdata = 32'h24020005;
        #1;
        tests++;
        if (stall !== 1'b0 || readdata !== 32'h24020005) begin
            fails++;
            $display("FAIL refill_forward: stall=%b readdata=%h, want 0/24020005", stall, readdata);
        end
        cyc();
        mem_valid = 1'b0;
        #1;
        tests++;
        if (stall !== 1'b0 || mem_read !== 1'b0 || readdata !== 32'h24020005) begin
            fails++;
            $display("FAIL reread_hit: stall=%b mem_read=%b readdata=%h, want 0/0/24020005", stall, mem_read, readdata);
        end
        read_en = 1'b0;
        cyc();
    endtask

    task automatic test_flush();
        logic st, mr;
        logic [31:0] rd, ma;
        probe(32'h40, 32'h24020005, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h24020005) begin
            fails++;
            $display("FAIL flush_prehit: stall=%b readdata=%h, want 0/24020005", st, rd);
        end
        do_flush();
        probe(32'h40, 32'h24020005, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1 || mr !== 1'b1) begin
            fails++;
            $display("FAIL flush_miss: stall=%b mem_read=%b, want 1/1", st, mr);
        end
        // flush coinciding with refill data: forwarded, not installed
        addr    = 32'h20;
        read_en = 1'b1;
        cyc();
        mem_valid    = 1'b1;
        mem_readdata = 32'hAAAA0001;
        flush        = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0 || readdata !== 32'hAAAA0001) begin
            fails++;
            $display("FAIL flush_fill_fwd: stall=%b readdata=%h, want 0/aaaa0001", stall, readdata);
        end
        cyc();
        flush     = 1'b0;
        mem_valid = 1'b0;
        read_en   = 1'b0;
        probe(32'h20, 32'hAAAA0002, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1) begin
            fails++;
            $display("FAIL flush_fill_noinstall: stall=%b, want 1", st);
        end
        // flush during refill without data: still waiting for memory
        addr    = 32'h60;
        read_en = 1'b1;
        cyc();
        flush = 1'b1;
        cyc();
        flush        = 1'b0;
        mem_valid    = 1'b1;
        mem_readdata = 32'hBBBB0003;
        #1;
        tests++;
        if (stall !== 1'b0 || readdata !== 32'hBBBB0003) begin
            fails++;
            $display("FAIL flush_refill_hold: stall=%b readdata=%h, want 0/bbbb0003", stall, readdata);
        end
        cyc();
        mem_valid = 1'b0;
        read_en   = 1'b0;
    endtask

    task automatic test_plru_order();
        logic st, mr;
        logic [31:0] rd, ma;
        do_flush();
        for (int k = 0; k < 4; k++) begin
            probe(32'(k * 32), 32'h1000 | 32'(k * 32), st, mr, rd, ma);
            tests++;
            if (st !== 1'b1) begin
                fails++;
                $display("FAIL order_fill%0d: stall=%b, want 1", k, st);
            end
        end
        probe(32'h80, 32'h1080, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1) begin
            fails++;
            $display("FAIL order_miss80: stall=%b, want 1", st);
        end
        probe(32'h80, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h1080) begin
            fails++;
            $display("FAIL order_hit80: stall=%b readdata=%h, want 0/00001080", st, rd);
        end
        probe(32'h00, 32'h1000, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1 || mr !== 1'b1) begin
            fails++;
            $display("FAIL order_evict00: stall=%b mem_read=%b, want 1/1", st, mr);
        end
        probe(32'h20, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h1020) begin
            fails++;
            $display("FAIL order_hit20: stall=%b readdata=%h, want 0/00001020", st, rd);
        end
    endtask

    task automatic test_plru_hit();
        logic st, mr;
        logic [31:0] rd, ma;
        do_flush();
        for (int k = 0; k < 4; k++) probe(32'(k * 32), 32'h1000 | 32'(k * 32), st, mr, rd, ma);
        probe(32'h00, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h1000) begin
            fails++;
            $display("FAIL phit_hit00: stall=%b readdata=%h, want 0/00001000", st, rd);
        end
        probe(32'h80, 32'h1080, st, mr, rd, ma);
        probe(32'h20, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h1020) begin
            fails++;
            $display("FAIL phit_hit20: stall=%b readdata=%h, want 0/00001020", st, rd);
        end
        probe(32'h40, 32'h1040, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1 || mr !== 1'b1) begin
            fails++;
            $display("FAIL phit_evict40: stall=%b mem_read=%b, want 1/1", st, mr);
        end
    endtask

    task automatic test_reset_abort();
        logic st, mr;
        logic [31:0] rd, ma;
        do_flush();
        addr    = 32'h60;
        read_en = 1'b1;
        cyc();
        tests++;
        if (mem_read !== 1'b1) begin
            fails++;
            $display("FAIL abort_refill: mem_read=%b, want 1", mem_read);
        end
        rst     = 1'b1;
        read_en = 1'b0;
        #1;
        tests++;
        if (mem_read !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL abort_rst_cycle: mem_read=%b stall=%b, want 0/0", mem_read, stall);
        end
        cyc();
        rst = 1'b0;
        #1;
        tests++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("FAIL abort_after: mem_read=%b, want 0", mem_read);
        end
        mem_valid    = 1'b1;
        mem_readdata = 32'hDEADBEEF;
        #1;
        tests++;
        if (stall !== 1'b0 || readdata !== 32'h0) begin
            fails++;
            $display("FAIL abort_late_valid: stall=%b readdata=%h, want 0/0", stall, readdata);
        end
        cyc();
        mem_valid = 1'b0;
        probe(32'h60, 32'h1060, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1 || mr !== 1'b1) begin
            fails++;
            $display("FAIL abort_remiss: stall=%b mem_read=%b, want 1/1", st, mr);
        end
    endtask

    task automatic test_idle_noop();
        logic st, mr;
        logic [31:0] rd, ma;
        do_flush();
        for (int k = 0; k < 4; k++) probe(32'(k * 32), 32'h1000 | 32'(k * 32), st, mr, rd, ma);
        for (int k = 0; k < 5; k++) begin
            read_en      = 1'b0;
            addr         = $urandom;
            mem_valid    = 1'b1;
            mem_readdata = $urandom;
            #1;
            tests++;
            if (stall !== 1'b0 || mem_read !== 1'b0 || readdata !== 32'h0) begin
                fails++;
                $display("FAIL noop_%0d: stall=%b mem_read=%b readdata=%h, want 0/0/0", k, stall, mem_read, readdata);
            end
            cyc();
        end
        mem_valid = 1'b0;
        probe(32'h80, 32'h1080, st, mr, rd, ma);
        probe(32'h20, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h1020) begin
            fails++;
            $display("FAIL noop_hit20: stall=%b readdata=%h, want 0/00001020", st, rd);
        end
        probe(32'h00, 32'h1000, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1) begin
            fails++;
            $display("FAIL noop_evict00: stall=%b, want 1", st);
        end
    endtask

    task automatic test_back_to_back();
        logic st, mr;
        logic [31:0] rd, ma;
        do_flush();
        probe(32'h4B, 32'h2048, st, mr, rd, ma);
        tests++;
        if (st !== 1'b1 || ma !== 32'h48) begin
            fails++;
            $display("FAIL b2b_maddr: stall=%b mem_addr=%h, want 1/00000048", st, ma);
        end
        probe(32'h04, 32'h2004, st, mr, rd, ma);
        probe(32'h05, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h2004) begin
            fails++;
            $display("FAIL b2b_hit04: stall=%b readdata=%h, want 0/00002004", st, rd);
        end
        probe(32'h4A, 32'h0, st, mr, rd, ma);
        tests++;
        if (st !== 1'b0 || rd !== 32'h2048) begin
            fails++;
            $display("FAIL b2b_hit48: stall=%b readdata=%h, want 0/00002048", st, rd);
        end
    endtask

    initial begin
        rst          = 1'b1;
        read_en      = 1'b0;
        flush        = 1'b0;
        mem_valid    = 1'b0;
        addr         = 32'h0;
        mem_readdata = 32'h0;
        test_reset();
        test_cold_miss();
        test_flush();
        test_plru_order();
        test_plru_hit();
        test_reset_abort();
        test_idle_noop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
